// File: rtl/uart_pkg.sv
// Shared types and default sizes for the UART receive path.
package uart_pkg;

    localparam int UART_DW            = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    // Capture FSM: IDLE waits for the receiver's ready level, ACK is the
    // single cycle in which the clear-ready pulse is high.
    typedef enum logic [0:0] {
        CAP_IDLE,
        CAP_ACK
    } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver / bus side and uart_rx_fifo.
// slave is the buffer's view, master is the view of whoever drives it.
//
// Handshakes:
//   receiver side: rx_rdy is a level held by the receiver until it samples
//   rx_clr_rdy=1 on a clock edge; rx_data is valid whenever rx_rdy=1. The
//   buffer raises rx_clr_rdy for exactly one cycle per captured byte.
//   bus side: rd_data always shows the head entry (first-word fall-through);
//   rd_en=1 on an edge with empty=0 consumes that entry, rd_en with empty=1
//   is ignored.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int DW    = UART_DW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx_rdy;
    logic [DW-1:0] rx_data;
    logic          rx_clr_rdy;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          ovf;
    logic          ovf_clr;
    logic [CW-1:0] thresh;
    logic          irq;
    cap_state_t    cap_state;   // debug view of the capture FSM

    modport slave (
        input  rx_rdy, rx_data, rd_en, ovf_clr, thresh,
        output rx_clr_rdy, rd_data, empty, full, count, ovf, irq, cap_state
    );

    modport master (
        output rx_rdy, rx_data, rd_en, ovf_clr, thresh,
        input  rx_clr_rdy, rd_data, empty, full, count, ovf, irq, cap_state
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO. A push while full is
// accepted only when a pop happens on the same edge; a pop while empty is
// ignored. full/empty come from the registered occupancy count.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wr_data,
    output logic [DW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each byte flagged by the receiver, pulses
// the receiver's clear-ready, and queues the byte for the bus side.
// Optional build macro UART_RX_FIFO_THRESH_EN adds a registered occupancy
// threshold interrupt; without it irq is constant 0 and thresh is ignored.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int DW    = UART_DW
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_fifo_if.slave   io
);
    localparam int CW = $clog2(DEPTH) + 1;

    cap_state_t state;
    logic       clr_q;
    logic       ovf_q;
    logic       irq_q;
    logic       push;
    logic       drop;

    // A byte is taken on the edge where IDLE sees rx_rdy; ACK ignores rx_rdy
    // so the still-high level is not captured twice.
    assign push = (state == CAP_IDLE) && io.rx_rdy;
    // Full with no simultaneous pop: the byte is lost but still acknowledged.
    assign drop = push && io.full && !io.rd_en;

    // Capture FSM with the registered clear-ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CAP_IDLE;
            clr_q <= 1'b0;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (io.rx_rdy) begin
                        state <= CAP_ACK;
                        clr_q <= 1'b1;
                    end else begin
                        clr_q <= 1'b0;
                    end
                end
                CAP_ACK: begin
                    state <= CAP_IDLE;
                    clr_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (io.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (io.rd_en),
        .wr_data (io.rx_data),
        .rd_data (io.rd_data),
        .count   (io.count),
        .full    (io.full),
        .empty   (io.empty)
    );

`ifdef UART_RX_FIFO_THRESH_EN
    logic          acc_push;
    logic          acc_pop;
    logic [CW-1:0] count_next;

    assign acc_pop  = io.rd_en && !io.empty;
    assign acc_push = push && (!io.full || acc_pop);

    // Occupancy after the coming edge, so irq lines up with the push itself.
    always_comb begin
        count_next = io.count + CW'(acc_push) - CW'(acc_pop);
    end

    // Threshold interrupt; thresh of zero disables it.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (count_next >= io.thresh) && (io.thresh != '0);
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^io.thresh;
    assign irq_q         = 1'b0;
`endif

    assign io.rx_clr_rdy = clr_q;
    assign io.ovf        = ovf_q;
    assign io.irq        = irq_q;
    assign io.cap_state  = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a receiver model feeds bytes from src_q, the bus
// side pops, and every cycle is compared with a queue-based reference.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];     // bytes the buffer should hold, head first
    logic [DW-1:0] src_q[$];     // bytes still waiting in the receiver
    bit            exp_ack;      // a byte was captured on the previous edge
    bit            exp_ovf;
    bit            exp_irq;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] last_pop;
    int            max_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = '0;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        src_q.delete();
        exp_q.delete();
        exp_ack = 1'b0;
        exp_ovf = 1'b0;
        exp_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full",  32'(bus.full),  32'd0);
        check("rst_ovf",   32'(bus.ovf),   32'd0);
        check("rst_clr",   32'(bus.rx_clr_rdy), 32'd0);
        check("rst_irq",   32'(bus.irq),   32'd0);
    endtask

    // One clock: drive rd_en/ovf_clr, predict the edge, then compare.
    task automatic step(input logic rd, input logic oclr);
        bit cap;
        bit pop;
        bit drop;
        bit clr_before;
        @(negedge clk);
        bus.rd_en   = rd;
        bus.ovf_clr = oclr;
        if (exp_q.size() > 0) begin
            check("rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
        end
        last_pop   = bus.rd_data;
        clr_before = bus.rx_clr_rdy;
        cap  = bus.rx_rdy && !exp_ack;
        pop  = rd && (exp_q.size() > 0);
        drop = cap && (exp_q.size() == DEPTH) && !pop;
        if (pop) begin
            void'(exp_q.pop_front());
        end
        if (cap && !drop) begin
            exp_q.push_back(bus.rx_data);
        end
        exp_ack = cap;
        if (drop) begin
            exp_ovf = 1'b1;
        end else if (oclr) begin
            exp_ovf = 1'b0;
        end
`ifdef UART_RX_FIFO_THRESH_EN
        exp_irq = (bus.thresh != 0) && (exp_q.size() >= int'(bus.thresh));
`else
        exp_irq = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("count", 32'(bus.count), 32'(exp_q.size()));
        check("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
        check("full",  32'(bus.full),  32'(exp_q.size() == DEPTH));
        check("ovf",   32'(bus.ovf),   32'(exp_ovf));
        check("clr_rdy", 32'(bus.rx_clr_rdy), 32'(cap));
        check("irq",   32'(bus.irq),   32'(exp_irq));
        check("state", 32'(bus.cap_state), exp_ack ? 32'(CAP_ACK) : 32'(CAP_IDLE));
        if (int'(bus.count) > max_count) begin
            max_count = int'(bus.count);
        end
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        // Receiver: drop ready on the edge that saw clear-ready, then offer the next byte.
        if (clr_before) begin
            bus.rx_rdy = 1'b0;
        end
        if (!bus.rx_rdy && src_q.size() > 0) begin
            bus.rx_rdy  = 1'b1;
            bus.rx_data = src_q.pop_front();
        end
    endtask

    // mode 0: no pops; 1: pop on capture cycles; 2: pop keeping count <= 2;
    // 3: random pops and clears; 4: ovf_clr on capture cycles
    task automatic run_idle(input int mode);
        int  guard;
        bit  capnow;
        logic rd;
        logic oc;
        guard = 0;
        while ((src_q.size() > 0 || bus.rx_rdy || exp_ack) && guard < 400) begin
            capnow = bus.rx_rdy && !exp_ack;
            rd = 1'b0;
            oc = 1'b0;
            case (mode)
                1: rd = capnow;
                2: rd = (exp_q.size() >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                3: begin
                    rd = 1'($urandom_range(0, 1));
                    oc = ($urandom_range(0, 7) == 0);
                end
                4: oc = capnow;
                default: rd = 1'b0;
            endcase
            step(rd, oc);
            guard++;
        end
        check("run_bound", 32'(guard < 400), 32'd1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 64) begin
            step(1'b1, 1'b0);
            guard++;
        end
        check("drain_bound", 32'(guard < 64), 32'd1);
    endtask

    initial begin
        int pulses;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = '0;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.thresh  = '0;
        max_count   = 0;

        // Single byte capture
        do_reset();
        src_q.push_back(8'hA5);
        step(1'b0, 1'b0);           // receiver raises rx_rdy
        pulses = 0;
        repeat (4) begin
            step(1'b0, 1'b0);
            pulses += int'(bus.rx_clr_rdy);
        end
        check("t1_pulses", 32'(pulses), 32'd1);
        check("t1_count", 32'(bus.count), 32'd1);
        check("t1_data", 32'(bus.rd_data), 32'hA5);
        check("t1_empty", 32'(bus.empty), 32'd0);

        // Fill to full plus one dropped byte, then drain in order
        do_reset();
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
        src_q.push_back(8'hFF);
        run_idle(0);
        check("t2_full", 32'(bus.full), 32'd1);
        check("t2_count", 32'(bus.count), 32'd16);
        check("t2_ovf", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            check("t2_pop", 32'(last_pop), 32'(i));
        end
        check("t2_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 1'b1);
        check("t2_ovf_clr", 32'(bus.ovf), 32'd0);

        // Push into a full FIFO together with a pop
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h10 + i));
        run_idle(0);
        src_q.push_back(8'h55);
        run_idle(1);
        check("t3_ovf", 32'(bus.ovf), 32'd0);
        check("t3_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        check("t3_last", 32'(last_pop), 32'h55);

        // Empty pop, then overflow drop coinciding with ovf_clr
        step(1'b1, 1'b0);
        check("t5_empty_pop", 32'(bus.count), 32'd0);
        for (int i = 0; i < 16; i++) src_q.push_back(8'($urandom));
        run_idle(0);
        src_q.push_back(8'hEE);
        run_idle(4);
        check("t5_ovf_set_wins", 32'(bus.ovf), 32'd1);
        step(1'b0, 1'b1);
        drain();

        // Wrap the pointers with light occupancy
        max_count = 0;
        for (int i = 0; i < 40; i++) src_q.push_back(8'(8'h30 + i));
        run_idle(2);
        drain();
        check("t4_max_count", 32'(max_count <= 2), 32'd1);

`ifdef UART_RX_FIFO_THRESH_EN
        // Threshold interrupt
        bus.thresh = CW'(4);
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hC0 + i));
        run_idle(0);
        check("t6_irq_on", 32'(bus.irq), 32'd1);
        step(1'b1, 1'b0);
        check("t6_irq_off", 32'(bus.irq), 32'd0);
        drain();
        bus.thresh = '0;
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hD0 + i));
        run_idle(0);
        check("t6_irq_dis", 32'(bus.irq), 32'd0);
        drain();
`endif

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            bus.thresh = CW'($urandom_range(0, DEPTH));
            for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom));
            run_idle(3);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
